// File: rtl/uart_frame_loader_pkg.sv
// uart_frame_loader_pkg
//   Shared constants and types for the UART frame loader.
//   Contents: frame geometry (PIXELS, ADDR_W), header byte, error-bit indices,
//   frame and receiver state enums, and the running checksum helper.
//   Optional feature macro: UART_FRAME_CHECKSUM_EN adds the CHECK state.
package uart_frame_loader_pkg;

    localparam int          PIXELS   = 784;
    localparam int          ADDR_W   = $clog2(PIXELS);
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    // Bit positions inside err: {timeout, overrun, framing}
    localparam int ERR_FRAMING = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_TIMEOUT = 2;

`ifdef UART_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2,
        ST_CHECK = 2'd3
    } frame_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } frame_state_e;
`endif

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Running XOR checksum over pixel bytes
    function automatic logic [7:0] ck_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader_if
//   Classifier-side pixel port and frame handshake.
//   rd_addr/frame_ack are driven by the classifier (master);
//   rd_data/frame_valid/loading/err are driven by the loader (slave).
interface uart_frame_loader_if;
    import uart_frame_loader_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_valid;
    logic              frame_ack;
    logic              loading;
    logic [2:0]        err;

    modport master (
        output rd_addr, frame_ack,
        input  rd_data, frame_valid, loading, err
    );

    modport slave (
        input  rd_addr, frame_ack,
        output rd_data, frame_valid, loading, err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, framing check.
//   Ports: clk, rst (sync active-low), rx (async line, idle high),
//          byte_stb (1-cycle pulse per good byte), byte_data, frame_err
//          (1-cycle pulse when a stop bit is sampled low).
module uart_rx_byte
    import uart_frame_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_stb,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             stb_q, stb_d;
    logic             ferr_q, ferr_d;

    // Synchronizer and receiver state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= CNT_ZERO;
            bit_idx_q  <= 3'd0;
            data_q     <= 8'h00;
            stb_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            stb_q      <= stb_d;
            ferr_q     <= ferr_d;
        end
    end

    // Bit timer, shifter and stop-bit check
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        stb_d      = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            // IDLE is only entered with the line high, so a low here is the start edge
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = CNT_ZERO;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d  = CNT_ZERO;
                    data_d = {rx_sync_q, data_q[7:1]};   // LSB arrives first
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = CNT_ZERO;
                    if (rx_sync_q) begin
                        stb_d      = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_stb  = stb_q;
    assign byte_data = data_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//   Receives a header-prefixed 28x28 8-bit image over UART into a frame
//   buffer and hands it to the classifier via a registered read port and a
//   valid/ack handshake. Optional macro UART_FRAME_CHECKSUM_EN appends an
//   XOR checksum byte that must match before the frame is presented.
//   Ports: clk, rst (sync active-low), rx (UART line),
//          bus (slave modport: rd_addr, rd_data, frame_valid, frame_ack,
//          loading, err = {timeout, overrun, framing}).
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 651,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    uart_frame_loader_if.slave  bus
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);

    logic              byte_stb;
    logic [7:0]        byte_data;
    logic              frame_err;

    frame_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]        err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              wr_en;
    logic              in_load;
    logic              tmo_expire;
    logic [7:0]        frame_buf [PIXELS];
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]        ck_q, ck_d;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_stb  (byte_stb),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

`ifdef UART_FRAME_CHECKSUM_EN
    assign in_load = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
    assign in_load = (state_q == ST_LOAD);
`endif
    // A byte in the same cycle as expiry wins over the timeout
    assign tmo_expire = in_load && (tmo_q == TMO_LAST) && !byte_stb;

    // Frame state, pointers, error flags and read-data registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= {ADDR_W{1'b0}};
            err_q     <= 3'b000;
            tmo_q     <= {TMO_W{1'b0}};
            rd_data_q <= 8'h00;
`ifdef UART_FRAME_CHECKSUM_EN
            ck_q      <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            rd_data_q <= rd_data_d;
`ifdef UART_FRAME_CHECKSUM_EN
            ck_q      <= ck_d;
`endif
        end
    end

    // Frame buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_buf[wr_ptr_q] <= byte_data;
        end
    end

    // Registered read port, zero for addresses beyond the frame
    always_comb begin
        rd_data_d = 8'h00;
        if (bus.rd_addr <= LAST_PIX) begin
            rd_data_d = frame_buf[bus.rd_addr];
        end else begin
            rd_data_d = 8'h00;
        end
    end

    // Idle-cycle counter, only running while a frame is being received
    always_comb begin
        tmo_d = tmo_q;
        if (!in_load || byte_stb) begin
            tmo_d = {TMO_W{1'b0}};
        end else begin
            tmo_d = tmo_q + TMO_W'(1'b1);
        end
    end

    // Frame FSM next-state and buffer write control
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        wr_en    = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        ck_d     = ck_q;
`endif
        if (frame_err) begin
            err_d[ERR_FRAMING] = 1'b1;
        end else begin
            err_d[ERR_FRAMING] = err_q[ERR_FRAMING];
        end
        case (state_q)
            ST_IDLE: begin
                if (byte_stb && (byte_data == HDR_BYTE)) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = {ADDR_W{1'b0}};
                    err_d    = 3'b000;
`ifdef UART_FRAME_CHECKSUM_EN
                    ck_d     = 8'h00;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (byte_stb) begin
                    wr_en = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                    ck_d  = ck_update(ck_q, byte_data);
`endif
                    // Pointer stops on the last pixel so it can never wrap
                    if (wr_ptr_q == LAST_PIX) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_FULL;
`endif
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1'b1);
                    end
                end else if (tmo_expire) begin
                    state_d            = ST_IDLE;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_stb) begin
                    if (byte_data == ck_q) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d            = ST_IDLE;
                        err_d[ERR_FRAMING] = 1'b1;
                    end
                end else if (tmo_expire) begin
                    state_d            = ST_IDLE;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_FULL: begin
                if (bus.frame_ack) begin
                    state_d = ST_IDLE;
                end else if (byte_stb) begin
                    err_d[ERR_OVERRUN] = 1'b1;   // byte dropped, buffer untouched
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.frame_valid = (state_q == ST_FULL);
    assign bus.loading     = in_load;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
`timescale 1ns/1ps
module tb_uart_frame_loader;
    import uart_frame_loader_pkg::*;

    localparam int CPB = 4;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst;
    logic rx;

    uart_frame_loader_if bus_if ();

    uart_frame_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Observed vector: {rd_data[7:0], loading, frame_valid, err[2:0]}
    typedef struct packed {
        logic [12:0] val;
        logic [12:0] mask;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    logic  req = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;

    // Scoreboard monitor: a request raised before an edge is checked just after it
    initial begin
        logic        pend;
        logic [12:0] act;
        exp_t        e;
        string       t;
        forever begin
            @(posedge clk);
            pend = req;
            #1;
            if (pend) begin
                act = {bus_if.rd_data, bus_if.loading, bus_if.frame_valid, bus_if.err};
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if ((act & e.mask) !== (e.val & e.mask)) begin
                        n_fail++;
                        $display("FAIL %s: got {rd_data,loading,valid,err}=%h want %h (mask %h) t=%0t",
                                 t, act, e.val, e.mask, $time);
                    end
                end
            end
        end
    end

    // Called at a negedge; the check lands after the next posedge
    task automatic expect_now(input logic [12:0] val, input logic [12:0] mask, input string tag);
        exp_t e;
        e.val  = val;
        e.mask = mask;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic chk_stat(input logic ld, input logic fv, input logic [2:0] er, input string tag);
        expect_now({8'h00, ld, fv, er}, 13'h001F, tag);
    endtask

    task automatic chk_rd(input int addr, input logic [7:0] d, input string tag);
        bus_if.rd_addr = ADDR_W'(addr);
        expect_now({d, 5'b00000}, 13'h1FE0, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_ramp(input int n);
        for (int i = 0; i < n; i++) send_byte(8'(i), 1'b1);
    endtask

    initial begin
        rst              = 1'b0;
        rx               = 1'b1;
        bus_if.frame_ack = 1'b0;
        bus_if.rd_addr   = '0;
        idle(3);
        expect_now(13'h0000, 13'h1FFF, "reset_state");
        rst = 1'b1;
        idle(4);

        // Garbage before the header is ignored
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(4);
        chk_stat(1'b0, 1'b0, 3'b000, "garbage_ignored");

        // Full frame of ramp bytes
        send_byte(HDR_BYTE, 1'b1);
        idle(4);
        chk_stat(1'b1, 1'b0, 3'b000, "header_loading");
        send_ramp(PIXELS);
`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(8'h00, 1'b1);          // XOR of the ramp frame
`endif
        idle(4);
        chk_stat(1'b0, 1'b1, 3'b000, "frame_valid");
        chk_rd(300, 8'h2C, "rd_300");
        chk_rd(0,   8'h00, "rd_0");
        chk_rd(255, 8'hFF, "rd_255");
        chk_rd(783, 8'h0F, "rd_783");

        // Overrun while the frame is held
        send_byte(8'h55, 1'b1);
        idle(4);
        chk_stat(1'b0, 1'b1, 3'b010, "overrun_flag");
        chk_rd(0,   8'h00, "rd_0_after_overrun");
        chk_rd(300, 8'h2C, "rd_300_after_overrun");

        // Ack releases the buffer on the same edge
        bus_if.frame_ack = 1'b1;
        chk_stat(1'b0, 1'b0, 3'b010, "ack_release");
        bus_if.frame_ack = 1'b0;

`ifdef UART_FRAME_CHECKSUM_EN
        // Back-to-back frame with a wrong checksum
        send_byte(HDR_BYTE, 1'b1);
        send_ramp(PIXELS);
        send_byte(8'hFF, 1'b1);
        idle(4);
        chk_stat(1'b0, 1'b0, 3'b001, "bad_checksum");
`endif

        // Header straight after ack/previous frame; then stall into timeout
        send_byte(HDR_BYTE, 1'b1);
        idle(4);
        chk_stat(1'b1, 1'b0, 3'b000, "header_clears_err");
        for (int j = 0; j < 100; j++) send_byte(8'(j) ^ 8'h5A, 1'b1);
        idle(50);
        chk_stat(1'b1, 1'b0, 3'b000, "before_timeout");
        idle(TMO);
        chk_stat(1'b0, 1'b0, 3'b100, "timeout");

        // Framing error mid-frame: bad byte dropped, reception continues
        send_byte(HDR_BYTE, 1'b1);
        idle(4);
        chk_stat(1'b1, 1'b0, 3'b000, "header2");
        for (int j = 0; j < 10; j++) send_byte(8'(j) + 8'h80, 1'b1);
        send_byte(8'hEE, 1'b0);
        idle(4);
        chk_stat(1'b1, 1'b0, 3'b001, "framing_flag");
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(4);
        chk_rd(9,  8'h89, "rd_9_before_bad");
        chk_rd(10, 8'h11, "rd_10_after_bad");
        chk_rd(11, 8'h22, "rd_11_after_bad");
        idle(TMO + 50);
        chk_stat(1'b0, 1'b0, 3'b101, "timeout_after_framing");

        // Reset in the middle of pixel 400
        send_byte(HDR_BYTE, 1'b1);
        send_ramp(400);
        rx = 1'b0;
        idle(CPB * 3);
        rx = 1'b1;
        chk_stat(1'b1, 1'b0, 3'b000, "loading_at_400");
        rst = 1'b0;
        expect_now(13'h0000, 13'h1FFF, "mid_frame_reset");
        rst = 1'b1;
        idle(CPB * 3);
        send_byte(8'h3C, 1'b1);
        idle(4);
        chk_stat(1'b0, 1'b0, 3'b000, "post_reset_idle");
        send_byte(HDR_BYTE, 1'b1);
        idle(4);
        chk_stat(1'b1, 1'b0, 3'b000, "post_reset_header");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

- Sits directly upstream of the digit classifier core, between the board `rx` pin and the classifier's pixel memory port.
- Deserialises 8N1 UART bytes and detects a frame header.
- Collects one 28×28 8-bit image into an internal frame buffer, then presents it to the classifier through a random-access read port and a valid/ack handshake.
- Guards against line noise, stalls and overrun so the classifier only ever sees complete frames.

## Interface
- `CLKS_PER_BIT`, 651: `clk` cycles per UART bit (6.25 MHz / 9600 baud); minimum 4.
- `PIXELS`, 784: bytes per frame.
- `TIMEOUT_CYC`, 65535: idle `clk` cycles allowed between bytes while loading.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous UART line, idle high.
- `rd_addr` in 10: pixel address for the classifier, range 0..PIXELS-1.
- `rd_data` out 8: pixel at `rd_addr`.
- `frame_valid` out 1: a complete frame is held in the buffer.
- `frame_ack` in 1: classifier has finished with the frame and releases the buffer.
- `loading` out 1: a frame is being received.
- `err` out 3: sticky error flags `{timeout, overrun, framing}`. Cleared by reset or by the next accepted header.

## Operation
- **RX front end**
  - `rx` passes through a 2-flop synchronizer.
  - Start bit is a falling edge, confirmed low at its mid-bit (`CLKS_PER_BIT/2`).
  - 8 data bits, LSB first, each sampled at mid-bit.
  - Stop bit is sampled at mid-bit. Stop bit low: byte discarded, `err[0]` set, receiver waits for line high before re-arming.
  - Each good byte produces a one-cycle `byte_stb` with `byte_data`.
- **Frame FSM**, states IDLE, LOAD, FULL, plus CHECK when the macro is enabled:
  - IDLE: byte 0xA5 → LOAD, `wr_ptr`=0, `err` cleared. Any other byte is ignored.
  - LOAD: each byte is written to `buf[wr_ptr]`, then `wr_ptr`++. The write of byte index PIXELS-1 → FULL (or CHECK).
  - LOAD timeout: `TIMEOUT_CYC` cycles with no `byte_stb` → IDLE, `err[2]` set, partial frame discarded.
  - FULL: `frame_valid`=1. Incoming bytes are not written, and the first such byte sets `err[1]`. `frame_ack` → IDLE on the next edge.
- `wr_ptr` never wraps; the frame length is exact.
- `frame_ack` outside FULL is ignored.
- `loading` = (state == LOAD or CHECK).
- The buffer is only written in LOAD, so contents are stable while `frame_valid`=1.

## Timing
- Reset values: `rd_data`=0, `frame_valid`=0, `loading`=0, `err`=0, state IDLE, `wr_ptr`=0, RX idle. Buffer contents are undefined after reset.
- `rx` to `byte_stb` latency: 2 sync cycles + 9.5×`CLKS_PER_BIT` ± 1 cycles.
- `byte_stb` to buffer write: same edge. `frame_valid` rises 1 cycle after the final byte's `byte_stb`.
- `rd_data` is registered: the value for `rd_addr` presented at edge N appears after edge N+1. Fixed 1-cycle latency, valid in every state.
- `frame_ack` is sampled at an edge where `frame_valid`=1; `frame_valid`=0 after that same edge.
- Back-to-back frames are allowed: a header arriving 1 cycle after the ack is accepted.
- Reset mid-byte or mid-frame: everything returns to reset values on the next edge, and the partial frame is dropped.
- Simultaneous timeout expiry and `byte_stb`: the byte wins, and the timeout counter reloads.

## Configuration
- `UART_FRAME_CHECKSUM_EN`
  - Defined: after byte PIXELS-1 the FSM enters CHECK and expects one more byte, the XOR of all pixel bytes.
    - Match → FULL.
    - Mismatch → IDLE with `err[0]` set; `frame_valid` never asserts.
    - Timeout applies in CHECK.
  - Undefined: no CHECK state; FULL follows the last pixel directly.

## Structure
- Shared package holds:
  - `PIXELS`
  - header constant `HDR_BYTE = 8'hA5`
  - FSM state enum
  - error bit index constants
  - address width `$clog2(PIXELS)`
- Sub-module `uart_rx_byte`: synchronizer, bit timer, 8N1 shifter, framing check. Outputs `byte_stb`/`byte_data`/`frame_err`.
- The loader wraps it, together with the FSM, timeout counter, checksum and inferred block-RAM buffer.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `TIMEOUT_CYC`=200.
- Send 0xA5, then bytes `i[7:0]` for i=0..783 → `frame_valid`=1. `rd_addr`=300 gives `rd_data`=0x2C one cycle later; `err`=0.
- Send 0x3C 0x00 before the header, then a full frame → garbage ignored; frame accepted with identical contents.
- Header + 100 bytes, then silence for 200 cycles → state IDLE, `err`=3'b100, `frame_valid` stays 0.
- Full frame, no ack, then 0x55 → `err[1]`=1; `rd_addr`=0 still returns 0x00. Assert `frame_ack` → `frame_valid`=0 next cycle.
- Byte with stop bit forced low → `err[0]`=1, byte not stored, following bytes still received.
- With `UART_FRAME_CHECKSUM_EN` defined:
  - Correct XOR checksum → `frame_valid`=1.
  - Wrong checksum (0xFF) → `frame_valid`=0, `err[0]`=1.
  - Drop `rst` low at pixel 400 → all outputs reset.
